pe_col_accum: RTL and testbench
===============================

// Module: pe_col_accum
// PURPOSE
//  Downstream stage of the bit-serial row filter. Sums N_ROWS consecutive row-filter results
//  (one per kernel row, time-multiplexed) plus a bias into one 2-D conv output.
//  Requantizes the sum (round + shift + saturate) and buffers it in a 2-entry valid/ready output FIFO.
//  Runs on the same fast clock as the row filter.
// PARAMETERS
//  BITWIDTH  8  pixel/weight width; input is 2*BITWIDTH signed, output is BITWIDTH signed
//  N_ROWS    3  row results summed per output (>=1)
//  SHIFT     0  arithmetic right shift applied before saturation (0..2*BITWIDTH-1)
// PORTS
//  clk            in   1           fast (bit-serial) clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  clear          in   1           sync: abandon partial sum, restart at row 0
//  din_valid      in   1           one-cycle pulse: din holds a row-filter result
//  din            in   2*BITWIDTH  signed row-filter result
//  bias           in   2*BITWIDTH  signed, sampled with the row-0 din_valid
//  dout_valid     out  1           FIFO not empty
//  dout_ready     in   1           consumer accepts dout this cycle
//  dout           out  BITWIDTH    signed requantized result (FIFO head)
//  row_idx        out  clog2(N_ROWS)+1  index of the next expected row
//  overflow       out  1           sticky: a result was dropped (FIFO full)
// BEHAVIOUR
//  Reset: acc=0, row_idx=0, FIFO empty, dout_valid=0, dout=0, overflow=0. All state async-cleared.
//  ACC_W = 2*BITWIDTH + clog2(N_ROWS+1) + 1; all adds sign-extended, no wrap inside acc.
//  din_valid with row_idx==0: acc <= bias + din; else acc <= acc + din; row_idx++.
//  din_valid with row_idx==N_ROWS-1: full sum requantized and pushed; row_idx <= 0.
//  Requant: r = (sum + (SHIFT ? 1<<(SHIFT-1) : 0)) >>> SHIFT; sat to [-2^(BW-1), 2^(BW-1)-1].
//  Latency: dout_valid rises the cycle after the last-row din_valid (FIFO was empty).
//  FIFO (2 entries): pop when dout_valid && dout_ready; dout = head; holds last popped value when empty.
//  Push while full: if a pop occurs in the same cycle, push accepted; else result dropped, overflow <= 1.
//  overflow clears only on rst.
//  clear: acc<=0, row_idx<=0; FIFO and overflow untouched.
//  clear && din_valid same cycle: din treated as row 0 (acc <= bias + din, row_idx <= 1).
//  din_valid while clear idle and no partial: normal. No din_ready: upstream cannot stall.
//  rst mid-accumulation: partial sum and FIFO contents discarded immediately.
// CONFIGURATION
//  PE_COL_ACCUM_RELU_EN defined: negative requantized results replaced by 0 before push.
//  PE_COL_ACCUM_RELU_EN undefined: signed results pass unchanged; no extra logic.
//  Latency identical in both builds.
// TESTING (BITWIDTH=8, N_ROWS=3, SHIFT=0 unless noted; dout_ready=1 unless noted)
//  1 din 10,20,-5, bias 0 -> dout_valid 1 cycle after 3rd pulse, dout=25; row_idx 1,2,0.
//  2 bias 3, din 200,100,50 -> sum 353 -> dout=127; din -200,-100,-50, bias 0 -> dout=-128.
//  3 SHIFT=2: sum 7 -> dout=2; sum -6 -> dout=-1; sum 6 -> dout=2.
//  4 din -2,-2,-1 -> dout=-5 (RELU undef) / dout=0 (RELU_EN defined).
//  5 dout_ready=0, three full sums 1,2,3 -> FIFO holds 1,2; third dropped, overflow=1;
//    then ready=1 -> dout 1 then 2, dout_valid falls, overflow stays 1.
//  6 din 10,20 then clear, then din 1,2,3 -> single dout=6; clear+din_valid(5) then 5,5 -> dout=15.
//  7 rst pulse after 2 rows with 1 FIFO entry -> dout_valid=0, row_idx=0; next 3 rows give a fresh sum.

Source files
------------

// File: rtl/pe_col_accum.sv
// Column accumulator: sums N_ROWS row-filter results plus bias, requantizes, and buffers in a 2-entry FIFO.
// Optional build macro PE_COL_ACCUM_RELU_EN clamps negative requantized results to zero.
module pe_col_accum #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned N_ROWS   = 3,
  parameter int unsigned SHIFT    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      din_valid,
  input  logic [2*BITWIDTH-1:0]     din,
  input  logic [2*BITWIDTH-1:0]     bias,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [BITWIDTH-1:0]       dout,
  output logic [$clog2(N_ROWS):0]   row_idx,
  output logic                      overflow
);

  localparam int unsigned IN_W  = 2 * BITWIDTH;
  localparam int unsigned RI_W  = $clog2(N_ROWS) + 1;
  localparam int unsigned ACC_W = IN_W + $clog2(N_ROWS + 1) + 1;
  localparam int unsigned RQ_W  = ACC_W + 1;

  localparam logic [RI_W-1:0]        LAST_ROW = RI_W'(N_ROWS - 1);
  localparam logic signed [RQ_W-1:0] RND      = RQ_W'((64'd1 << SHIFT) >> 1);
  localparam logic signed [RQ_W-1:0] SAT_MAX  = RQ_W'((64'd1 << (BITWIDTH - 1)) - 64'd1);
  localparam logic signed [RQ_W-1:0] SAT_MIN  = ~SAT_MAX;

  logic signed [IN_W-1:0]   din_s, bias_s;
  logic signed [ACC_W-1:0]  acc_q, acc_d, base_c, sum_c;
  logic [RI_W-1:0]          row_q, row_d, eff_row_c;
  logic                     push_c, pop_c;
  logic signed [RQ_W-1:0]   rnd_c, shr_c;
  logic [BITWIDTH-1:0]      sat_c, res_c;
  logic [BITWIDTH-1:0]      head_q, head_d, tail_q, tail_d;
  logic [1:0]               cnt_q, cnt_d;
  logic                     valid_q, valid_d, ovf_q, ovf_d;

  assign din_s  = din;
  assign bias_s = bias;

  // Row sequencing; a clear in the same cycle as din_valid makes that sample row 0.
  always_comb begin
    eff_row_c = clear ? '0 : row_q;
    base_c    = (eff_row_c == '0) ? ACC_W'(bias_s) : acc_q;
    sum_c     = base_c + ACC_W'(din_s);
    push_c    = din_valid && (eff_row_c == LAST_ROW);
    acc_d     = acc_q;
    row_d     = row_q;
    if (din_valid) begin
      acc_d = sum_c;
      row_d = (eff_row_c == LAST_ROW) ? '0 : RI_W'(eff_row_c + 1'b1);
    end else if (clear) begin
      acc_d = '0;
      row_d = '0;
    end
  end

  // Round-half-up, arithmetic shift, saturate to the signed output range.
  always_comb begin
    rnd_c = RQ_W'(sum_c) + RND;
    shr_c = rnd_c >>> SHIFT;
    if (shr_c > SAT_MAX)      sat_c = BITWIDTH'(SAT_MAX);
    else if (shr_c < SAT_MIN) sat_c = BITWIDTH'(SAT_MIN);
    else                      sat_c = BITWIDTH'(shr_c);
`ifdef PE_COL_ACCUM_RELU_EN
    res_c = sat_c[BITWIDTH-1] ? '0 : sat_c;
`else
    res_c = sat_c;
`endif
  end

  // Two-entry FIFO as head/tail registers; head doubles as the output and holds after the last pop.
  always_comb begin
    pop_c  = valid_q && dout_ready;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    case (cnt_q)
      2'd0: begin
        if (push_c) begin
          head_d = res_c;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push_c && pop_c) begin
          head_d = res_c;
        end else if (push_c) begin
          tail_d = res_c;
          cnt_d  = 2'd2;
        end else if (pop_c) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        if (pop_c) begin
          head_d = tail_q;
          if (push_c) tail_d = res_c;
          else        cnt_d  = 2'd1;
        end else if (push_c) begin
          ovf_d = 1'b1;
        end
      end
    endcase
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      row_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      row_q   <= row_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout       = head_q;
  assign dout_valid = valid_q;
  assign row_idx    = row_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pe_col_accum.sv
// Directed bench for pe_col_accum: SHIFT=0 and SHIFT=2 instances share stimulus, each with its own expected queue.
module tb_pe_col_accum;

  logic        clk = 1'b0;
  logic        rst, clear, din_valid, dout_ready;
  logic [15:0] din, bias;
  logic        v0, v2, ov0, ov2;
  logic [7:0]  d0, d2;
  logic [2:0]  r0, r2;

  int q0[$];
  int q2[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_col_accum #(.BITWIDTH(8), .N_ROWS(3), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .din_valid(din_valid), .din(din), .bias(bias),
    .dout_valid(v0), .dout_ready(dout_ready), .dout(d0), .row_idx(r0), .overflow(ov0)
  );

  pe_col_accum #(.BITWIDTH(8), .N_ROWS(3), .SHIFT(2)) u_s2 (
    .clk(clk), .rst(rst), .clear(clear), .din_valid(din_valid), .din(din), .bias(bias),
    .dout_valid(v2), .dout_ready(dout_ready), .dout(d2), .row_idx(r2), .overflow(ov2)
  );

  function automatic int relu(input int x);
`ifdef PE_COL_ACCUM_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input int d, input int b);
    din       = 16'(d);
    bias      = 16'(b);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic rows3(input int a, input int b, input int c, input int bs);
    row(a, bs);
    row(b, 77);
    row(c, 77);
  endtask

  task automatic push(input int e0, input int e2);
    q0.push_back(relu(e0));
    q2.push_back(relu(e2));
  endtask

  // Checks the current FIFO head of both instances against the scoreboard front.
  task automatic check_head(input string tag);
    int e0, e2;
    if (q0.size() == 0 || q2.size() == 0) begin
      chk({tag, ".qempty"}, 1, 0);
    end else begin
      e0 = q0.pop_front();
      e2 = q2.pop_front();
      chk({tag, ".v0"}, v0, 1);
      chk({tag, ".d0"}, $signed(d0), e0);
      chk({tag, ".v2"}, v2, 1);
      chk({tag, ".d2"}, $signed(d2), e2);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; din_valid = 1'b0; din = '0; bias = '0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst.valid", v0, 0);
    chk("rst.dout", d0, 0);
    chk("rst.row", r0, 0);
    chk("rst.ovf", ov0, 0);

    // Basic sum, latency and row index progression.
    row(10, 0);  chk("t1.row1", r0, 1);
    row(20, 77); chk("t1.row2", r0, 2);
    chk("t1.early", v0, 0);
    push(25, 6);
    row(-5, 77); chk("t1.row0", r0, 0);
    check_head("t1");
    step();
    chk("t1.drained", v0, 0);
    chk("t1.hold0", $signed(d0), relu(25));
    chk("t1.hold2", $signed(d2), relu(6));

    // Saturation both ways, bias sampled only with row 0.
    push(127, 88);   rows3(200, 100, 50, 3);    check_head("t2.pos"); step();
    push(-128, -87); rows3(-200, -100, -50, 0); check_head("t2.neg"); step();

    // Rounding at the SHIFT=2 instance.
    push(7, 2);  rows3(7, 0, 0, 0);  check_head("t3.p7");  step();
    push(-6, -1); rows3(-6, 0, 0, 0); check_head("t3.m6"); step();
    push(6, 2);  rows3(6, 0, 0, 0);  check_head("t3.p6");  step();

    // Negative result (clamped in the ReLU build).
    push(-5, -1); rows3(-2, -2, -1, 0); check_head("t4"); step();

    // Full FIFO with a pop in the same cycle as a push: no drop.
    dout_ready = 1'b0;
    push(4, 1); rows3(4, 0, 0, 0);
    push(5, 1); rows3(5, 0, 0, 0);
    row(6, 0); row(0, 77);
    dout_ready = 1'b1;
    check_head("cc.a");
    push(6, 2);
    row(0, 77);
    check_head("cc.b"); step();
    check_head("cc.c"); step();
    chk("cc.drained", v0, 0);
    chk("cc.ovf", ov0, 0);

    // Full FIFO without pop: third result dropped, overflow sticky.
    dout_ready = 1'b0;
    push(1, 0); rows3(1, 0, 0, 0);
    chk("t5.v1", v0, 1);
    push(2, 1); rows3(2, 0, 0, 0);
    rows3(3, 0, 0, 0);
    chk("t5.ovf0", ov0, 1);
    chk("t5.ovf2", ov2, 1);
    dout_ready = 1'b1;
    check_head("t5.a"); step();
    check_head("t5.b"); step();
    chk("t5.drained", v0, 0);
    chk("t5.ovf_stay", ov0, 1);
    chk("t5.hold", $signed(d0), relu(2));

    // Clear abandons the partial sum; clear with din_valid starts row 0.
    row(10, 0); row(20, 77);
    clear = 1'b1; step(); clear = 1'b0;
    chk("t6.clr_row", r0, 0);
    push(6, 2); rows3(1, 2, 3, 0); check_head("t6.a"); step();
    row(9, 0);
    clear = 1'b1; row(5, 0); clear = 1'b0;
    chk("t6.cd_row", r0, 1);
    push(15, 4); row(5, 77); row(5, 77); check_head("t6.b"); step();

    // Reset mid-accumulation with one entry buffered.
    dout_ready = 1'b0;
    rows3(1, 0, 0, 0);
    row(10, 0); row(20, 77);
    chk("t7.pre_row", r0, 2);
    chk("t7.pre_v", v0, 1);
    rst = 1'b1;
    #1;
    chk("t7.v", v0, 0);
    chk("t7.row", r0, 0);
    chk("t7.ovf", ov0, 0);
    chk("t7.dout", d0, 0);
    step();
    rst = 1'b0;
    dout_ready = 1'b1;
    push(15, 4); rows3(4, 5, 6, 0); check_head("t7.fresh"); step();
    chk("t7.drained", v0, 0);
    chk("end.qempty", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
